// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the 4-bit ALU command issuer.
package alu_pkg;

    localparam logic [2:0] OPT_ADD = 3'b000;
    localparam logic [2:0] OPT_SUB = 3'b001;
    localparam logic [2:0] OPT_SLT = 3'b110;
    localparam logic [2:0] OPT_EQ  = 3'b111;

    // Bit positions inside the 5-bit {less, equal, carry, overflow, zero} flag vector
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_EQUAL = 3;
    localparam int FLAG_LESS  = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    typedef struct packed {
        logic [3:0] result;
        logic [4:0] flags;
        logic       illegal;
    } rsp_entry_t;

    function automatic logic opt_uses_cin(input logic [2:0] opt);
        return (opt == OPT_SUB) || (opt == OPT_SLT) || (opt == OPT_EQ);
    endfunction

    function automatic logic opt_is_legal(input logic [2:0] opt);
        return (opt == OPT_ADD) || opt_uses_cin(opt);
    endfunction

endpackage

// File: rtl/alu_core_4bits.sv
// Combinational 4-bit add/sub/compare datapath producing result, flags and illegal-opcode marker.
module alu_core_4bits
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] opt,
    output logic [3:0] result,
    output logic [4:0] flags,
    output logic       illegal
);

    logic       cin;
    logic [3:0] bx;
    logic [4:0] sum;
    logic       ovf;
    logic       zero;

    // Subtract-style opcodes invert B and inject a carry; illegal opcodes fall through as add
    always_comb begin
        cin     = opt_uses_cin(opt);
        bx      = b ^ {4{cin}};
        sum     = {1'b0, a} + {1'b0, bx} + {4'b0000, cin};
        ovf     = (a[3] == bx[3]) && (sum[3] != a[3]);
        zero    = (sum[3:0] == 4'd0);
        result  = sum[3:0];
        illegal = !opt_is_legal(opt);

        flags             = '0;
        flags[FLAG_ZERO]  = zero;
        flags[FLAG_OVF]   = ovf;
        flags[FLAG_CARRY] = sum[4];
        flags[FLAG_EQUAL] = (opt == OPT_EQ) && zero;
        flags[FLAG_LESS]  = (opt == OPT_SLT) && (ovf ^ sum[3]);
    end

endmodule

// File: rtl/alu_cmd_issuer_4bits.sv
// Accepts ALU commands, executes them one per two cycles and queues responses in a small FIFO.
module alu_cmd_issuer_4bits
    import alu_pkg::*;
#(
    parameter int RSP_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_opt,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic [4:0] rsp_flags,
    output logic       rsp_illegal,
    input  logic       clr_sticky,
    output logic       sticky_ovf,
    output logic [7:0] op_count
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(RSP_DEPTH);

    logic [0:0]       state;
    logic [3:0]       lat_a;
    logic [3:0]       lat_b;
    logic [2:0]       lat_opt;
    rsp_entry_t       fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    rsp_entry_t       exec_entry;
    rsp_entry_t       head;
    logic             push;
    logic             pop;
    logic             handshake;

    alu_core_4bits u_core (
        .a       (lat_a),
        .b       (lat_b),
        .opt     (lat_opt),
        .result  (exec_entry.result),
        .flags   (exec_entry.flags),
        .illegal (exec_entry.illegal)
    );

    // cmd_ready is gated by rst_n so nothing is accepted while reset is held
    assign cmd_ready = rst_n && (state == ST_IDLE) && (count < DEPTH_CNT);
    assign handshake = cmd_valid && cmd_ready;
    assign push      = (state == ST_EXEC);
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;

    assign head        = fifo_mem[rd_ptr];
    assign rsp_result  = head.result;
    assign rsp_flags   = head.flags;
    assign rsp_illegal = head.illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            lat_a   <= '0;
            lat_b   <= '0;
            lat_opt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        state   <= ST_EXEC;
                        lat_a   <= cmd_a;
                        lat_b   <= cmd_b;
                        lat_opt <= cmd_opt;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= exec_entry;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
            op_count   <= '0;
        end else begin
            if (push && exec_entry.flags[FLAG_OVF]) begin
                sticky_ovf <= 1'b1;
            end else if (clr_sticky) begin
                sticky_ovf <= 1'b0;
            end
            if (push) begin
                op_count <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/alu_cmd_issuer_4bits.md
ALU_CMD_ISSUER_4BITS -- requirements
Module: alu_cmd_issuer_4bits

Interface
REQ-001 SHALL have parameter RSP_DEPTH, default 2, response FIFO entries (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid&cmd_ready.
REQ-006 SHALL have port cmd_a  input  4  signed operand A.
REQ-007 SHALL have port cmd_b  input  4  signed operand B.
REQ-008 SHALL have port cmd_opt  input  3  opcode: 000 add, 001 sub, 110 signed-less, 111 equal, others illegal.
REQ-009 SHALL have port rsp_valid  output  1  response available.
REQ-010 SHALL have port rsp_ready  input  1  response consumed when rsp_valid&rsp_ready.
REQ-011 SHALL have port rsp_result  output  4  ALU result.
REQ-012 SHALL have port rsp_flags  output  5  {less, equal, carry, overflow, zero}.
REQ-013 SHALL have port rsp_illegal  output  1  opcode of this response was illegal.
REQ-014 SHALL have port clr_sticky  input  1  synchronous clear of sticky_ovf.
REQ-015 SHALL have port sticky_ovf  output  1  any pushed response had overflow=1 since last clear.
REQ-016 SHALL have port op_count  output  8  number of responses pushed, modulo 256.

Function
REQ-017 SHALL implement FSM IDLE/EXEC: IDLE->EXEC on command handshake (operands, opcode latched); EXEC->IDLE unconditionally after one cycle.
REQ-018 SHALL drive cmd_ready = (state==IDLE) && (FIFO count < RSP_DEPTH); throughput one command per 2 cycles.
REQ-019 SHALL in EXEC compute from latched operands: cin = opt in {001,110,111}; Bx = B XOR {4{cin}}; {carry,result} = A + Bx + cin (5-bit).
REQ-020 SHALL compute overflow = (A[3]==Bx[3]) && (result[3]!=A[3]); zero = (result==0).
REQ-021 SHALL set less = overflow XOR result[3] only for opt 110, else 0; equal = zero only for opt 111, else 0.
REQ-022 SHALL treat illegal opcodes as add (cin=0) and set rsp_illegal=1 for that entry.
REQ-023 SHALL push {result, flags, illegal} into the FIFO at the end of the EXEC cycle; rsp_valid rises the next cycle (handshake-to-rsp_valid latency 2 cycles when FIFO empty).
REQ-024 SHALL present FIFO head combinationally on rsp_* while rsp_valid=1; rsp_* held stable while rsp_valid&!rsp_ready.
REQ-025 SHALL keep count unchanged on simultaneous push and pop; pointers wrap modulo RSP_DEPTH; responses in command order.
REQ-026 SHALL never push when full (guaranteed by REQ-018) and never pop when empty.
REQ-027 SHALL set sticky_ovf on any push with overflow=1; clr_sticky clears it; simultaneous set and clear -> set wins.
REQ-028 SHALL increment op_count on each push, wrapping 255->0.

Reset
REQ-029 SHALL on rst_n=0 asynchronously force: state=IDLE, FIFO empty, rsp_valid=0, cmd_ready=0 while in reset, sticky_ovf=0, op_count=0, latched operands 0.
REQ-030 SHALL discard any command in EXEC when reset asserts; no response produced for it.

Structure
REQ-031 SHALL place opcode constants (OPT_ADD, OPT_SUB, OPT_SLT, OPT_EQ), flag bit indices and FSM state encoding in shared package alu_pkg.
REQ-032 SHALL implement REQ-019..022 in one combinational sub-module alu_core_4bits; FIFO and FSM in the top.

Verification
REQ-033 SHALL check add A=0111, B=0001 -> result 1000, flags less0 eq0 carry0 ovf1 zero0, sticky_ovf=1.
REQ-034 SHALL check sub A=0011, B=0011 -> result 0000, carry1 ovf0 zero1; opt 111 same operands -> equal=1.
REQ-035 SHALL check slt A=1000, B=0001 -> result 0111, carry1 ovf1 less1; opt 101 A=0010, B=0011 -> result 0101, rsp_illegal=1.
REQ-036 SHALL check backpressure: rsp_ready=0, 3 commands offered -> 2 accepted, cmd_ready stays 0; rsp_ready=1 -> 3rd accepted, 3 responses in order.
REQ-037 SHALL check rst_n pulsed low during EXEC -> no rsp_valid afterwards, op_count=0, sticky_ovf=0.
REQ-038 SHALL check 256 pushes -> op_count returns to 0; clr_sticky coincident with an overflow push -> sticky_ovf=1.
